// File: rtl/pcpi_issuer.sv
// PCPI initiator: takes one command upstream, drives the PCPI request, returns the result downstream.
// Optional define PCPI_TIMEOUT_EN aborts requests left unclaimed for TIMEOUT_CYCLES idle cycles.
module pcpi_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic        pcpi_busy,
  input  logic [31:0] pcpi_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic [7:0]  rsp_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state_q, state_d;
  logic   timeout_hit;

  assign cmd_ready = (state_q == IDLE);

`ifdef PCPI_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Ready arriving in the same cycle as the timeout takes priority.
  assign timeout_hit = (state_q == ISSUE) && !pcpi_ready && !pcpi_busy &&
                       (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state_q != ISSUE || pcpi_busy || pcpi_ready) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  logic unused_ok;

  assign timeout_hit = 1'b0;
  assign unused_ok   = ^{pcpi_busy, (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   if (pcpi_ready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_wr     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_cycles <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pcpi_valid <= 1'b1;
            pcpi_insn  <= cmd_insn;
            pcpi_rs1   <= cmd_rs1;
            pcpi_rs2   <= cmd_rs2;
            rsp_cycles <= '0;
          end
        end
        ISSUE: begin
          if (rsp_cycles != '1) rsp_cycles <= rsp_cycles + 8'd1;
          if (pcpi_ready) begin
            pcpi_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_data   <= pcpi_wr ? pcpi_rd : '0;
            rsp_wr     <= pcpi_wr;
            rsp_err    <= 1'b0;
          end else if (timeout_hit) begin
            pcpi_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_wr     <= 1'b0;
            rsp_err    <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
